// File: rtl/iter_divider_if.sv
// Execute-stage <-> divider handshake bundle (request, operands, result).
interface iter_divider_if #(
    parameter int unsigned XLEN = 64
);
    logic            i_flush;
    logic            i_stall;
    logic            i_e;
    logic [1:0]      i_op;
    logic            i_w32;
    logic [XLEN-1:0] i_src1;
    logic [XLEN-1:0] i_src2;
    logic            o_valid;
    logic            o_busy;
    logic [XLEN-1:0] o_dest;

    // Execute side: issues requests, consumes results
    modport master (
        output i_flush, i_stall, i_e, i_op, i_w32, i_src1, i_src2,
        input  o_valid, o_busy, o_dest
    );

    // Divider side
    modport slave (
        input  i_flush, i_stall, i_e, i_op, i_w32, i_src1, i_src2,
        output o_valid, o_busy, o_dest
    );
endinterface

// File: rtl/iter_divider.sv
// Multi-cycle radix-2 restoring divider for RV64 DIV/DIVU/REM/REMU and W forms.
// Optional macro DIV_EARLY_OUT_EN: skip iteration when |dividend| < |divisor|.
module iter_divider #(
    parameter int unsigned XLEN  = 64,
    parameter int unsigned CNT_W = 7
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [31:0] i_log_fd,
    iter_divider_if.slave bus
);
    localparam int unsigned HALF = XLEN / 2;

    typedef enum logic [1:0] {IDLE, ITER, FIX, DONE} state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [XLEN-1:0]   rem_q, rem_d;
    logic [XLEN-1:0]   quo_q, quo_d;
    logic [XLEN-1:0]   div_q, div_d;
    logic [XLEN-1:0]   dest_q, dest_d;
    logic [1:0]        op_q, op_d;
    logic              w32_q, w32_d;
    logic              neg_a_q, neg_a_d;
    logic              neg_b_q, neg_b_d;

    logic              is_signed_c, a_neg_c, b_neg_c, a_min_c, ovf_c;
    logic [XLEN-1:0]   a_ext_c, b_ext_c, a_mag_c, b_mag_c;
    logic [XLEN:0]     rem_sh_c, rem_sub_c;
    logic              fits_c;
    logic [XLEN-1:0]   quo_fix_c, rem_fix_c, fix_res_c;

    // Narrow results keep only the low half, sign-extended from bit HALF-1
    function automatic logic [XLEN-1:0] sext_w(input logic w, input logic [XLEN-1:0] v);
        return w ? {{HALF{v[HALF-1]}}, v[HALF-1:0]} : v;
    endfunction

    // Decode incoming operands: width extension, signs, magnitudes, overflow case
    always_comb begin
        is_signed_c = ~bus.i_op[0];
        if (bus.i_w32) begin
            a_ext_c = {{HALF{is_signed_c & bus.i_src1[HALF-1]}}, bus.i_src1[HALF-1:0]};
            b_ext_c = {{HALF{is_signed_c & bus.i_src2[HALF-1]}}, bus.i_src2[HALF-1:0]};
            a_min_c = (bus.i_src1[HALF-1:0] == {1'b1, {(HALF-1){1'b0}}});
        end else begin
            a_ext_c = bus.i_src1;
            b_ext_c = bus.i_src2;
            a_min_c = (bus.i_src1 == {1'b1, {(XLEN-1){1'b0}}});
        end
        a_neg_c = is_signed_c & a_ext_c[XLEN-1];
        b_neg_c = is_signed_c & b_ext_c[XLEN-1];
        a_mag_c = a_neg_c ? XLEN'(-a_ext_c) : a_ext_c;
        b_mag_c = b_neg_c ? XLEN'(-b_ext_c) : b_ext_c;
        ovf_c   = is_signed_c & a_min_c & (b_ext_c == '1);
    end

    // One restoring step plus final sign correction
    always_comb begin
        rem_sh_c  = {rem_q, quo_q[XLEN-1]};
        rem_sub_c = rem_sh_c - {1'b0, div_q};
        fits_c    = (rem_sh_c >= {1'b0, div_q});
        quo_fix_c = (~op_q[0] & (neg_a_q ^ neg_b_q)) ? XLEN'(-quo_q) : quo_q;
        rem_fix_c = (~op_q[0] & neg_a_q) ? XLEN'(-rem_q) : rem_q;
        fix_res_c = sext_w(w32_q, op_q[1] ? rem_fix_c : quo_fix_c);
    end

    // Next-state and datapath update
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        div_d   = div_q;
        dest_d  = dest_q;
        op_d    = op_q;
        w32_d   = w32_q;
        neg_a_d = neg_a_q;
        neg_b_d = neg_b_q;
        if (bus.i_flush) begin
            state_d = IDLE;
            cnt_d   = '0;
            dest_d  = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.i_e) begin
                        op_d    = bus.i_op;
                        w32_d   = bus.i_w32;
                        neg_a_d = a_neg_c;
                        neg_b_d = b_neg_c;
                        div_d   = b_mag_c;
                        if (b_ext_c == '0) begin
                            dest_d  = sext_w(bus.i_w32, bus.i_op[1] ? a_ext_c : '1);
                            state_d = DONE;
                        end else if (ovf_c) begin
                            dest_d  = sext_w(bus.i_w32, bus.i_op[1] ? '0 : a_ext_c);
                            state_d = DONE;
`ifdef DIV_EARLY_OUT_EN
                        end else if (a_mag_c < b_mag_c) begin
                            quo_d   = '0;
                            rem_d   = a_mag_c;
                            state_d = FIX;
`endif
                        end else begin
                            // Narrow dividend sits in the upper half so it shifts into rem first
                            rem_d   = '0;
                            quo_d   = bus.i_w32 ? (a_mag_c << HALF) : a_mag_c;
                            cnt_d   = bus.i_w32 ? CNT_W'(HALF) : CNT_W'(XLEN);
                            state_d = ITER;
                        end
                    end
                end
                ITER: begin
                    if (fits_c) begin
                        rem_d = rem_sub_c[XLEN-1:0];
                        quo_d = {quo_q[XLEN-2:0], 1'b1};
                    end else begin
                        rem_d = rem_sh_c[XLEN-1:0];
                        quo_d = {quo_q[XLEN-2:0], 1'b0};
                    end
                    cnt_d = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        state_d = FIX;
                    end
                end
                FIX: begin
                    dest_d  = fix_res_c;
                    state_d = DONE;
                end
                DONE: begin
                    if (bus.i_e && !bus.i_stall) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // State and datapath registers
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            div_q   <= '0;
            dest_q  <= '0;
            op_q    <= '0;
            w32_q   <= 1'b0;
            neg_a_q <= 1'b0;
            neg_b_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            div_q   <= div_d;
            dest_q  <= dest_d;
            op_q    <= op_d;
            w32_q   <= w32_d;
            neg_a_q <= neg_a_d;
            neg_b_q <= neg_b_d;
        end
    end

    assign bus.o_valid = (state_q == DONE);
    assign bus.o_busy  = (state_q != IDLE);
    assign bus.o_dest  = dest_q;

`ifndef SYNTHESIS
    // Simulation-only transaction log
    always_ff @(posedge i_clk) begin
        if (!i_rst && !bus.i_flush && i_log_fd != 32'd0) begin
            if (state_q == IDLE && bus.i_e) begin
                $display("[DIV] start op=%0d w32=%0d src1=%h src2=%h",
                         bus.i_op, bus.i_w32, bus.i_src1, bus.i_src2);
            end
            if (state_q != DONE && state_d == DONE) begin
                $display("[DIV] done result=%h", dest_d);
            end
        end
    end
`endif
endmodule

// File: tb/tb_iter_divider.sv
// Randomized self-checking bench for iter_divider against an arithmetic reference.
// Build with +define+DIV_EARLY_OUT_EN to exercise the early-out latency.
module tb_iter_divider;
    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] log_fd;
    int          n_checks = 0;
    int          n_pass   = 0;

    always #5 clk = ~clk;

    iter_divider_if dif ();

    iter_divider dut (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_log_fd(log_fd),
        .bus     (dif.slave)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // RISC-V M-extension result from plain arithmetic
    function automatic logic [63:0] ref_div(input logic [1:0] op, input logic w32,
                                            input logic [63:0] a, input logic [63:0] b);
        int              sa, sb;
        int unsigned     ua, ub;
        longint          la, lb;
        logic [31:0]     r32;
        logic [63:0]     r64;
        sa = int'(a[31:0]);
        sb = int'(b[31:0]);
        ua = a[31:0];
        ub = b[31:0];
        la = longint'(a);
        lb = longint'(b);
        if (w32) begin
            if (ub == 0) r32 = op[1] ? ua : 32'hFFFF_FFFF;
            else if (!op[0] && a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF)
                r32 = op[1] ? 32'd0 : a[31:0];
            else if (!op[0]) r32 = op[1] ? 32'(sa % sb) : 32'(sa / sb);
            else r32 = op[1] ? (ua % ub) : (ua / ub);
            return {{32{r32[31]}}, r32};
        end
        if (b == 64'd0) r64 = op[1] ? a : 64'hFFFF_FFFF_FFFF_FFFF;
        else if (!op[0] && a == 64'h8000_0000_0000_0000 && b == 64'hFFFF_FFFF_FFFF_FFFF)
            r64 = op[1] ? 64'd0 : a;
        else if (!op[0]) r64 = op[1] ? 64'(la % lb) : 64'(la / lb);
        else r64 = op[1] ? (a % b) : (a / b);
        return r64;
    endfunction

    // Cycle (after the request cycle) in which o_valid first rises
    function automatic int ref_lat(input logic [1:0] op, input logic w32,
                                   input logic [63:0] a, input logic [63:0] b);
`ifdef DIV_EARLY_OUT_EN
        logic [63:0] ma, mb;
`endif
        if (w32) begin
            if (b[31:0] == 32'd0) return 1;
            if (!op[0] && a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF) return 1;
        end else begin
            if (b == 64'd0) return 1;
            if (!op[0] && a == 64'h8000_0000_0000_0000 && b == 64'hFFFF_FFFF_FFFF_FFFF) return 1;
        end
`ifdef DIV_EARLY_OUT_EN
        if (w32) begin
            ma = (!op[0] && a[31]) ? 64'(-longint'(int'(a[31:0]))) : {32'd0, a[31:0]};
            mb = (!op[0] && b[31]) ? 64'(-longint'(int'(b[31:0]))) : {32'd0, b[31:0]};
        end else begin
            ma = (!op[0] && a[63]) ? 64'(-a) : a;
            mb = (!op[0] && b[63]) ? 64'(-b) : b;
        end
        if (ma < mb) return 2;
`endif
        return w32 ? 34 : 66;
    endfunction

    function automatic logic [63:0] rand_opnd();
        case ($urandom_range(0, 5))
            0: return 64'($urandom_range(0, 20));
            1: return {32'($urandom), 32'($urandom)};
            2: return 64'(-64'($urandom_range(1, 20)));
            3: return 64'h8000_0000_0000_0000;
            4: return 64'hFFFF_FFFF_FFFF_FFFF;
            default: return 64'hFFFF_FFFF_8000_0000;
        endcase
    endfunction

    // Issue one request, wait for the result, optionally stall in DONE, then consume
    task automatic run_op(input string tag, input logic [1:0] op, input logic w32,
                          input logic [63:0] a, input logic [63:0] b, input int stall_cyc);
        logic [63:0] exp_res;
        int          exp_l;
        int          n;
        exp_res = ref_div(op, w32, a, b);
        exp_l   = ref_lat(op, w32, a, b);
        dif.i_op    = op;
        dif.i_w32   = w32;
        dif.i_src1  = a;
        dif.i_src2  = b;
        dif.i_e     = 1'b1;
        dif.i_stall = (stall_cyc > 0);
        @(posedge clk); #1;
        n = 1;
        // Later operand changes must not disturb the latched request
        dif.i_src1 = {32'($urandom), 32'($urandom)};
        dif.i_src2 = {32'($urandom), 32'($urandom)};
        dif.i_op   = 2'($urandom);
        dif.i_w32  = 1'($urandom);
        check_eq({tag, " busy"}, 64'(dif.o_busy), 64'd1);
        while (!dif.o_valid && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        check_eq({tag, " latency"}, 64'(n), 64'(exp_l));
        if (dif.o_valid) begin
            check_eq({tag, " dest"}, dif.o_dest, exp_res);
            for (int i = 0; i < stall_cyc; i++) begin
                @(posedge clk); #1;
                check_eq({tag, " stall valid"}, 64'(dif.o_valid), 64'd1);
                check_eq({tag, " stall dest"}, dif.o_dest, exp_res);
            end
            dif.i_stall = 1'b0;
            @(posedge clk); #1;
            check_eq({tag, " consumed valid"}, 64'(dif.o_valid), 64'd0);
            check_eq({tag, " consumed busy"}, 64'(dif.o_busy), 64'd0);
        end
        dif.i_e     = 1'b0;
        dif.i_stall = 1'b0;
    endtask

    initial begin
        logic [1:0]  rop;
        logic        rw;
        logic [63:0] ra, rb;
        log_fd      = 32'd0;
        rst         = 1'b1;
        dif.i_flush = 1'b0;
        dif.i_stall = 1'b0;
        dif.i_e     = 1'b0;
        dif.i_op    = 2'b00;
        dif.i_w32   = 1'b0;
        dif.i_src1  = '0;
        dif.i_src2  = '0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("reset valid", 64'(dif.o_valid), 64'd0);
        check_eq("reset busy", 64'(dif.o_busy), 64'd0);
        check_eq("reset dest", dif.o_dest, 64'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        run_op("div -7/2", 2'b00, 1'b0, 64'(-64'd7), 64'd2, 0);
        run_op("rem -7/2", 2'b10, 1'b0, 64'(-64'd7), 64'd2, 0);
        run_op("divu 100/7", 2'b01, 1'b0, 64'd100, 64'd7, 0);
        run_op("remu 100/7", 2'b11, 1'b0, 64'd100, 64'd7, 0);
        run_op("divu 9/3 b2b", 2'b01, 1'b0, 64'd9, 64'd3, 0);
        run_op("divu 5/0", 2'b01, 1'b0, 64'd5, 64'd0, 0);
        run_op("remu 5/0", 2'b11, 1'b0, 64'd5, 64'd0, 0);
        run_op("div ovf", 2'b00, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 0);
        run_op("rem ovf", 2'b10, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 0);
        run_op("divw ovf", 2'b00, 1'b1, 64'hFFFF_FFFF_8000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 0);
        run_op("divuw", 2'b01, 1'b1, 64'h1_0000_0010, 64'd4, 0);

        // Flush ten cycles into the iteration
        dif.i_op   = 2'b01;
        dif.i_w32  = 1'b0;
        dif.i_src1 = 64'd1000;
        dif.i_src2 = 64'd3;
        dif.i_e    = 1'b1;
        @(posedge clk); #1;
        repeat (9) @(posedge clk);
        #1;
        check_eq("flush pre busy", 64'(dif.o_busy), 64'd1);
        check_eq("flush pre valid", 64'(dif.o_valid), 64'd0);
        dif.i_flush = 1'b1;
        dif.i_e     = 1'b0;
        @(posedge clk); #1;
        check_eq("flush busy", 64'(dif.o_busy), 64'd0);
        check_eq("flush valid", 64'(dif.o_valid), 64'd0);
        check_eq("flush dest", dif.o_dest, 64'd0);
        dif.i_flush = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check_eq("post flush valid", 64'(dif.o_valid), 64'd0);
        end
        run_op("divu 8/2", 2'b01, 1'b0, 64'd8, 64'd2, 0);

        run_op("stall divu", 2'b01, 1'b0, 64'd100, 64'd7, 5);
        run_op("divu 3/10", 2'b01, 1'b0, 64'd3, 64'd10, 0);

        for (int k = 0; k < 30; k++) begin
            rop = 2'($urandom);
            rw  = 1'($urandom);
            ra  = rand_opnd();
            rb  = rand_opnd();
            run_op($sformatf("rand%0d op%0d w%0d", k, rop, rw), rop, rw, ra, rb,
                   int'($urandom_range(0, 2)));
            if ($urandom_range(0, 1) == 1) begin
                @(posedge clk); #1;
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
